my_cnt: RTL and testbench

Parameterised N-bit synchronous up-counter with a count enable and a synchronous clear. It is a general-purpose event and cycle counter for datapath and control blocks: it counts enabled clock cycles, wraps at a programmable modulus, and flags the terminal count so that counters can be cascaded.

---
 rtl/my_cnt.sv | 63 ++++++
 tb/tb_my_cnt.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/my_cnt.sv
// my_cnt -- parameterised N-bit synchronous up-counter with modulus wrap.
//
// Counts enabled clock cycles from 0 to MODULUS-1, then wraps to 0. A
// synchronous clear has priority over the enable. The terminal-count flag is
// combinational so it can drive the enable of a following cascaded stage
// without adding a cycle of latency per stage.
//
// Parameters:
//   N        counter width in bits (1..32)
//   MODULUS  sequence length (2..2**N); the count runs 0..MODULUS-1
//
// Ports:
//   clk   in   rising-edge clock
//   clr   in   synchronous active-high clear (cnt <= 0, wrap <= 0)
//   ena   in   count enable
//   cnt   out  current count, straight from the register
//   tc    out  ena & (cnt == MODULUS-1), combinational
//   wrap  out  registered one-cycle pulse after the count wrapped to 0

module my_cnt #(
  parameter int unsigned     N       = 4,
  parameter longint unsigned MODULUS = longint'(1) << N
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ena,
  output logic [N-1:0] cnt,
  output logic         tc,
  output logic         wrap
);

  // Largest value the count may legally hold. For MODULUS == 2**N this is
  // all-ones, so the wrap below is the natural N-bit rollover.
  localparam logic [N-1:0] last_val = N'(MODULUS - 1);

  // The counter has no asynchronous reset; it is undefined after power-up
  // until the first edge that samples clr high.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with <= so every register samples
    // the pre-edge value of cnt; blocking = here would create ordering races.
    if (clr) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (ena) begin
      // ">=" rather than "==" so an out-of-range value (e.g. after an upset)
      // recovers to 0 on the next enabled edge instead of running on.
      if (cnt >= last_val) begin
        cnt  <= '0;
        wrap <= 1'b1;
      end else begin
        cnt  <= cnt + N'(1);
        wrap <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

  // Deliberately independent of clr: clr reaches the outputs only through
  // the register, so there is no combinational clr-to-output path.
  assign tc = ena & (cnt == last_val);

endmodule

// File: tb/tb_my_cnt.sv
// tb_my_cnt -- self-checking bench for my_cnt.
//
// Two instances share clk/clr/ena: a power-of-two counter (N=4, MODULUS=16)
// and a non-power-of-two counter (N=4, MODULUS=10). For every driven cycle a
// behavioural model predicts the post-edge cnt/wrap, which is pushed into a
// per-instance queue and popped for comparison after the edge. tc is checked
// against the model before each edge.

module tb_my_cnt;

  typedef struct packed {
    logic [3:0] cnt;
    logic       wrap;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       ena = 1'b0;
  logic [3:0] cnt16, cnt10;
  logic       tc16, tc10, wrap16, wrap10;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t q16[$];
  exp_t q10[$];

  // Behavioural model state for each instance.
  int m16_cnt = 0;
  int m10_cnt = 0;
  bit m_valid = 1'b0;

  always #10 clk = ~clk;

  my_cnt #(.N(4), .MODULUS(16)) dut16 (
    .clk (clk),
    .clr (clr),
    .ena (ena),
    .cnt (cnt16),
    .tc  (tc16),
    .wrap(wrap16)
  );

  my_cnt #(.N(4), .MODULUS(10)) dut10 (
    .clk (clk),
    .clr (clr),
    .ena (ena),
    .cnt (cnt10),
    .tc  (tc10),
    .wrap(wrap10)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Model of one edge for a counter of modulus m.
  function automatic exp_t model_next(input int cur, input int m,
                                      input bit c, input bit e);
    exp_t r;
    if (c) begin
      r.cnt = 4'd0; r.wrap = 1'b0;
    end else if (e) begin
      if (cur >= m - 1) begin
        r.cnt = 4'd0; r.wrap = 1'b1;
      end else begin
        r.cnt = 4'(cur + 1); r.wrap = 1'b0;
      end
    end else begin
      r.cnt = 4'(cur); r.wrap = 1'b0;
    end
    return r;
  endfunction

  // Drive one cycle, check tc before the edge, score cnt/wrap after it.
  task automatic step(input bit c, input bit e);
    exp_t x16, x10, g16, g10;
    @(negedge clk);
    clr = c;
    ena = e;
    #1;
    if (m_valid) begin
      check("tc16", 32'(tc16), 32'(e && (m16_cnt == 15)));
      check("tc10", 32'(tc10), 32'(e && (m10_cnt == 9)));
    end
    x16 = model_next(m16_cnt, 16, c, e);
    x10 = model_next(m10_cnt, 10, c, e);
    if (c) m_valid = 1'b1;
    q16.push_back(x16);
    q10.push_back(x10);
    m16_cnt = int'(x16.cnt);
    m10_cnt = int'(x10.cnt);
    @(posedge clk);
    #1;
    if (m_valid) begin
      g16 = q16.pop_front();
      g10 = q10.pop_front();
      check("cnt16",  32'(cnt16),  32'(g16.cnt));
      check("wrap16", 32'(wrap16), 32'(g16.wrap));
      check("cnt10",  32'(cnt10),  32'(g10.cnt));
      check("wrap10", 32'(wrap10), 32'(g10.wrap));
      check("cnt10_range", 32'(cnt10 < 4'd10), 32'd1);
    end else begin
      void'(q16.pop_front());
      void'(q10.pop_front());
    end
  endtask

  // Enabled counting until the modulus-16 model reaches target (bounded).
  task automatic run_to(input int target, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m16_cnt == target) begin
        hit = 1'b1;
        break;
      end
      step(1'b0, 1'b1);
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    // Reset with ena high: clear wins on every edge.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    check("reset_cnt16", 32'(cnt16), 32'd0);
    check("reset_tc16",  32'(tc16),  32'd0);

    // Release: 1, 2, 3, ... then free-run through the wrap of both counters.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);

    // Enable hold at 7.
    run_to(7, "reach_7");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    check("hold_cnt16", 32'(cnt16), 32'd7);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);

    // Clear mid-count at 11 with ena high, then resume from 1.
    run_to(11, "reach_11");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check("resume_cnt16", 32'(cnt16), 32'd1);

    // Clear together with ena at the terminal count: wrap suppressed.
    run_to(15, "reach_15");
    step(1'b1, 1'b1);
    check("clr_at_tc_wrap16", 32'(wrap16), 32'd0);

    // Wrap directly from terminal count, then the cycle after.
    run_to(15, "reach_15b");
    step(1'b0, 1'b1);
    check("wrap_pulse16", 32'(wrap16), 32'd1);
    step(1'b0, 1'b1);
    check("wrap_gone16", 32'(wrap16), 32'd0);

    // Irregular enable pattern with occasional clears.
    for (int i = 0; i < 80; i++)
      step(($urandom_range(0, 19) == 0), $urandom_range(0, 2) != 0);

    check("queue16_empty", 32'(q16.size()), 32'd0);
    check("queue10_empty", 32'(q10.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
